// File: rtl/glitc_trigger_generator_if.sv
// Bus between the trigger-register slice / correlator and the trigger generator.
// Member names match the legacy port names so existing wiring maps one-to-one.
interface glitc_trigger_generator_if #(
  parameter int MAX_WIDTH    = 12,
  parameter int WIN_WIDTH    = 4,
  parameter int HOLD_WIDTH   = 8,
  parameter int SCALER_WIDTH = 16
);
  logic                    sync_i;
  logic [MAX_WIDTH-1:0]    r0_max_i;
  logic [MAX_WIDTH-1:0]    r1_max_i;
  logic [MAX_WIDTH-1:0]    r0_thresh_i;
  logic [MAX_WIDTH-1:0]    r1_thresh_i;
  logic [1:0]              mode_i;
  logic [WIN_WIDTH-1:0]    window_i;
  logic [HOLD_WIDTH-1:0]   holdoff_i;
  logic                    trig_o;
  logic                    trig_phase_o;
  logic                    busy_o;
  logic [SCALER_WIDTH-1:0] r0_scaler_o;
  logic [SCALER_WIDTH-1:0] r1_scaler_o;
  logic [SCALER_WIDTH-1:0] trig_scaler_o;
  logic                    scaler_valid_o;

  modport master (
    output sync_i, r0_max_i, r1_max_i, r0_thresh_i, r1_thresh_i,
    output mode_i, window_i, holdoff_i,
    input  trig_o, trig_phase_o, busy_o,
    input  r0_scaler_o, r1_scaler_o, trig_scaler_o, scaler_valid_o
  );

  modport slave (
    input  sync_i, r0_max_i, r1_max_i, r0_thresh_i, r1_thresh_i,
    input  mode_i, window_i, holdoff_i,
    output trig_o, trig_phase_o, busy_o,
    output r0_scaler_o, r1_scaler_o, trig_scaler_o, scaler_valid_o
  );
endinterface

// File: rtl/glitc_trigger_generator.sv
// Trigger decision stage after the dual-RITC correlator: thresholds both maxima,
// forms OR / windowed-AND / R0-only triggers with holdoff, and keeps rate scalers.
module glitc_trigger_generator #(
  parameter int MAX_WIDTH     = 12,
  parameter int WIN_WIDTH     = 4,
  parameter int HOLD_WIDTH    = 8,
  parameter int SCALER_WIDTH  = 16,
  parameter int SCALER_PERIOD = 162500000
) (
  input logic                      clk_i,
  input logic                      rst_n_i,
  glitc_trigger_generator_if.slave bus
);

  localparam int PERIOD_WIDTH = (SCALER_PERIOD > 1) ? $clog2(SCALER_PERIOD) : 1;
  localparam logic [PERIOD_WIDTH-1:0] PERIOD_LAST = PERIOD_WIDTH'(SCALER_PERIOD - 1);
  localparam logic [PERIOD_WIDTH-1:0] PERIOD_ONE  = PERIOD_WIDTH'(1);
  localparam logic [WIN_WIDTH-1:0]    WIN_ONE     = WIN_WIDTH'(1);
  localparam logic [HOLD_WIDTH-1:0]   HOLD_ONE    = HOLD_WIDTH'(1);
  localparam logic [SCALER_WIDTH-1:0] SCALER_ONE  = SCALER_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    MODE_OFF = 2'b00,
    MODE_OR  = 2'b01,
    MODE_AND = 2'b10,
    MODE_R0  = 2'b11
  } mode_t;

  mode_t                   mode;
  state_t                  state;
  logic                    r0_hit, r1_hit;
  logic                    r0_hit_d, r1_hit_d;
  logic                    r0_rise, r1_rise;
  logic [WIN_WIDTH-1:0]    r0_win, r1_win;
  logic                    r0_open, r1_open;
  logic                    decision, fire;
  logic [HOLD_WIDTH-1:0]   hold_cnt;
  logic                    trig, trig_phase, busy;
  logic [PERIOD_WIDTH-1:0] period_cnt;
  logic                    period_wrap;
  logic [SCALER_WIDTH-1:0] r0_cnt, r1_cnt, trig_cnt;
  logic [SCALER_WIDTH-1:0] r0_scaler, r1_scaler, trig_scaler;
  logic                    scaler_valid;

  function automatic logic [SCALER_WIDTH-1:0] sat_inc(input logic [SCALER_WIDTH-1:0] v);
    return (v == '1) ? v : v + SCALER_ONE;
  endfunction

  assign mode = mode_t'(bus.mode_i);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r0_hit   <= 1'b0;
      r1_hit   <= 1'b0;
      r0_hit_d <= 1'b0;
      r1_hit_d <= 1'b0;
    end else begin
      r0_hit   <= (bus.r0_max_i > bus.r0_thresh_i);
      r1_hit   <= (bus.r1_max_i > bus.r1_thresh_i);
      r0_hit_d <= r0_hit;
      r1_hit_d <= r1_hit;
    end
  end

  always_comb begin
    r0_rise  = r0_hit & ~r0_hit_d;
    r1_rise  = r1_hit & ~r1_hit_d;
    r0_open  = r0_hit | (r0_win != '0);
    r1_open  = r1_hit | (r1_win != '0);
    decision = 1'b0;
    case (mode)
      MODE_OR:  decision = r0_hit | r1_hit;
      MODE_AND: decision = (r0_hit & r1_open) | (r1_hit & r0_open);
      MODE_R0:  decision = r0_hit;
      default:  decision = 1'b0;
    endcase
    fire        = (state == ARMED) && (mode != MODE_OFF) && decision;
    period_wrap = (period_cnt == PERIOD_LAST);
  end

  // Clearing on the firing edge wins over a load, so the hits that caused a
  // trigger cannot reopen a window; hits seen during holdoff still load.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r0_win <= '0;
      r1_win <= '0;
    end else if (state == IDLE || mode == MODE_OFF || fire) begin
      r0_win <= '0;
      r1_win <= '0;
    end else begin
      if (r0_hit)              r0_win <= bus.window_i;
      else if (r0_win != '0)   r0_win <= r0_win - WIN_ONE;
      if (r1_hit)              r1_win <= bus.window_i;
      else if (r1_win != '0)   r1_win <= r1_win - WIN_ONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      busy       <= 1'b0;
      trig       <= 1'b0;
      trig_phase <= 1'b0;
    end else begin
      trig       <= fire;
      trig_phase <= fire & bus.sync_i;
      if (mode == MODE_OFF) begin
        state    <= IDLE;
        hold_cnt <= '0;
        busy     <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= ARMED;
          ARMED: begin
            if (fire && bus.holdoff_i != '0) begin
              state    <= HOLDOFF;
              hold_cnt <= bus.holdoff_i;
              busy     <= 1'b1;
            end
          end
          HOLDOFF: begin
            if (hold_cnt <= HOLD_ONE) begin
              state    <= ARMED;
              hold_cnt <= '0;
              busy     <= 1'b0;
            end else begin
              hold_cnt <= hold_cnt - HOLD_ONE;
            end
          end
          default: begin
            state    <= IDLE;
            hold_cnt <= '0;
            busy     <= 1'b0;
          end
        endcase
      end
    end
  end

  // An event on the wrap cycle seeds the next period instead of the latched one.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      period_cnt   <= '0;
      r0_cnt       <= '0;
      r1_cnt       <= '0;
      trig_cnt     <= '0;
      r0_scaler    <= '0;
      r1_scaler    <= '0;
      trig_scaler  <= '0;
      scaler_valid <= 1'b0;
    end else if (period_wrap) begin
      period_cnt   <= '0;
      r0_scaler    <= r0_cnt;
      r1_scaler    <= r1_cnt;
      trig_scaler  <= trig_cnt;
      scaler_valid <= 1'b1;
      r0_cnt       <= r0_rise ? SCALER_ONE : '0;
      r1_cnt       <= r1_rise ? SCALER_ONE : '0;
      trig_cnt     <= trig    ? SCALER_ONE : '0;
    end else begin
      period_cnt   <= period_cnt + PERIOD_ONE;
      scaler_valid <= 1'b0;
      if (r0_rise) r0_cnt   <= sat_inc(r0_cnt);
      if (r1_rise) r1_cnt   <= sat_inc(r1_cnt);
      if (trig)    trig_cnt <= sat_inc(trig_cnt);
    end
  end

  assign bus.trig_o         = trig;
  assign bus.trig_phase_o   = trig_phase;
  assign bus.busy_o         = busy;
  assign bus.r0_scaler_o    = r0_scaler;
  assign bus.r1_scaler_o    = r1_scaler;
  assign bus.trig_scaler_o  = trig_scaler;
  assign bus.scaler_valid_o = scaler_valid;

endmodule
